jt12_wrsched: RTL
=================

Name: jt12_wrsched

Overview:
CPU-side write scheduler for the FM core register file.
- Latches per-part register addresses and queues data writes in a small FIFO.
- Issues queued writes to the core only on clock-enabled cycles where the core reports it is ready.
- Generates the busy flag that the status read-back path returns to the CPU.
- Sits between the CPU bus decode and the FM core; its busy output feeds the status byte.

Parameters:
DEPTH_LOG2, 2, FIFO depth is 2**DEPTH_LOG2 entries (default 4).
BUSY_CYCLES, 32, clk cycles the busy counter runs after each accepted data write; legal range 1 to 255.

Ports:
rst_n  input  1  asynchronous reset, active-low.
clk  input  1  CPU clock.
cen  input  1  FM core clock enable; writes are issued/consumed only on cen cycles.
cpu_wr  input  1  single-clk write strobe.
cpu_addr  input  2  A0=0 address write, A0=1 data write; A1 selects part (0/1).
cpu_din  input  8  CPU write data.
core_ready  input  1  core can accept a write on this cen cycle.
core_we  output  1  write request level to core.
core_part  output  1  part of the issued write.
core_reg  output  8  register number of the issued write.
core_din  output  8  data of the issued write.
busy  output  1  status busy flag.
overflow  output  1  sticky flag: a data write was dropped because the FIFO was full.
fifo_level  output  DEPTH_LOG2+1  current FIFO occupancy.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO is emptied; both address latches are 0; the busy counter is 0.
  - core_we=0, core_part=0, core_reg=0, core_din=0, busy=0, overflow=0, fifo_level=0.
  - Asserting reset mid-operation discards queued writes immediately; core_we drops without waiting for a clk edge.
- Address write (cpu_wr=1, A0=0): reg_addr[A1] <= cpu_din. No FIFO entry is made and busy is unaffected.
- Data write (cpu_wr=1, A0=1): push {A1, reg_addr[A1], cpu_din}.
  - Accepted if the FIFO is not full, or if it is full and a pop occurs on the same edge.
  - On acceptance the busy counter loads BUSY_CYCLES, reloading even if it is already running.
  - If not accepted: the write is dropped, overflow <= 1, and the counter is unchanged.
- An address write and a data write cannot coincide (single strobe). A data write uses reg_addr as it stood before that edge.
- Pop condition: cen & core_ready & FIFO non-empty, sampled at the clk edge. The head entry moves to core_part/core_reg/core_din.
- core_we update:
  - On a pop: core_we <= 1.
  - Else if cen=1: core_we <= 0.
  - Otherwise core_we holds.
  - Result: core_we is high from the pop edge until the next cen edge. Back-to-back pops on consecutive cen edges keep core_we high while data advances.
- core_part/core_reg/core_din change only on a pop and hold afterwards.
- There is no bypass: a write pushed into an empty FIFO pops no earlier than the following cen edge, giving a minimum of 1 clk from push to core_we.
- Busy counter:
  - Decrements by 1 every clk while non-zero.
  - A reload on an edge takes priority over decrement.
  - Saturates at 0.
- busy = (counter != 0) | (fifo_level != 0) | core_we. It is combinational from registers.
- fifo_level:
  - Push only: +1. Pop only: -1. Both on the same edge: unchanged.
  - Read and write pointers wrap modulo depth.
- overflow clears only on reset.
- FIFO ordering is strict first-in first-out across both parts.

Test Plan:
- Reset with writes queued: drive rst_n=0 with fifo_level=3 -> core_we=0, busy=0, fifo_level=0, overflow=0 immediately, without waiting for a clk edge.
- Single write: address write 0x28 to part 0, then data write 0xF0, with cen every clk and core_ready=1 -> one edge later core_we=1, core_reg=0x28, core_din=0xF0, core_part=0. busy stays 1 for 32 clk after the data write, then 0.
- Part separation: address 0x30 to part 1, address 0xA4 to part 0, then data 0x11 to part 1 and 0x22 to part 0 -> issued in order (1,0x30,0x11) then (0,0xA4,0x22).
- Backpressure and full FIFO: core_ready=0, 5 data writes with DEPTH_LOG2=2 -> fifo_level=4 and overflow=1; the 5th write's data is never issued. Then core_ready=1 -> 4 pops in FIFO order and fifo_level returns to 0.
- Full FIFO with simultaneous pop: FIFO full, data write on the same edge as a pop -> write accepted, fifo_level stays 4, overflow stays 0.
- cen gating: cen high every 4th clk, 2 queued writes -> core_we high for exactly 4 clk per write, with pops only on cen edges; busy remains 1 until core_we falls and the counter expires.

Source files
------------

// File: rtl/jt12_wrsched.sv
// CPU-side write scheduler for the FM core: latches per-part register addresses,
// queues data writes and hands them to the core on ready cen cycles.
module jt12_wrsched #(
  parameter int DEPTH_LOG2  = 2,
  parameter int BUSY_CYCLES = 32
) (
  input  logic                  rst_n,
  input  logic                  clk,
  input  logic                  cen,
  input  logic                  cpu_wr,
  input  logic [1:0]            cpu_addr,
  input  logic [7:0]            cpu_din,
  input  logic                  core_ready,
  output logic                  core_we,
  output logic                  core_part,
  output logic [7:0]            core_reg,
  output logic [7:0]            core_din,
  output logic                  busy,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   fifo_level
);
  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0]         LVL_ONE  = LW'(1);
  localparam logic [LW-1:0]         LVL_FULL = LW'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [7:0]            CNT_LOAD = 8'(BUSY_CYCLES);

  // entry layout: {part, register, data}
  logic [1:0][7:0]              reg_addr_q, reg_addr_d;
  logic [DEPTH-1:0][16:0]       mem_q, mem_d;
  logic [DEPTH_LOG2-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]                level_q, level_d;
  logic [7:0]                   cnt_q, cnt_d;
  logic                         we_q, we_d;
  logic                         part_q, part_d;
  logic [7:0]                   reg_q, reg_d, din_q, din_d;
  logic                         ovf_q, ovf_d;

  logic pop, push_req, push;

  always_comb begin
    pop      = cen & core_ready & (level_q != '0);
    push_req = cpu_wr & cpu_addr[0];
    // a full FIFO still accepts when the head leaves on the same edge
    push     = push_req & ((level_q != LVL_FULL) | pop);

    reg_addr_d = reg_addr_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    part_d     = part_q;
    reg_d      = reg_q;
    din_d      = din_q;
    ovf_d      = ovf_q;

    if (cpu_wr && !cpu_addr[0])
      reg_addr_d[cpu_addr[1]] = cpu_din;

    if (push) begin
      mem_d[wr_ptr_q] = {cpu_addr[1], reg_addr_q[cpu_addr[1]], cpu_din};
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else if (push_req) begin
      ovf_d = 1'b1;
    end

    if (pop) begin
      {part_d, reg_d, din_d} = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      we_d     = 1'b1;
    end else if (cen) begin
      we_d = 1'b0;
    end

    if (push && !pop)      level_d = level_q + LVL_ONE;
    else if (pop && !push) level_d = level_q - LVL_ONE;

    if (push)               cnt_d = CNT_LOAD;
    else if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_addr_q <= '0;
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      part_q     <= 1'b0;
      reg_q      <= '0;
      din_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      reg_addr_q <= reg_addr_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      part_q     <= part_d;
      reg_q      <= reg_d;
      din_q      <= din_d;
      ovf_q      <= ovf_d;
    end
  end

  assign core_we    = we_q;
  assign core_part  = part_q;
  assign core_reg   = reg_q;
  assign core_din   = din_q;
  assign overflow   = ovf_q;
  assign fifo_level = level_q;
  assign busy       = (cnt_q != 8'd0) | (level_q != '0) | we_q;
endmodule
